dump_control: RTL and testbench

Sequencer for the squeeze/output stage of the SHAKE core. Accepts an output-length request, consumes rate blocks from the permutation stage one at a time, and drives the dump datapath's load/shift/counter/masking controls so that exactly the requested number of bytes leaves as a stream of w-bit words under a valid/ready handshake. Sits between the permutation stage (block source) and the external output port, alongside the dump datapath it controls.

---
 rtl/dump_control_if.sv | 33 +++
 rtl/dump_control.sv | 151 +++++++++++++++
 tb/tb_dump_control.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dump_control_if.sv
// Handshake bundle for the SHAKE squeeze sequencer: request,
// rate-block source and output word stream.
interface dump_control_if #(
  parameter int SIZE_WIDTH = 32
);
  logic                  start;
  logic [SIZE_WIDTH-1:0] output_size;
  logic [1:0]            operation_mode;
  logic                  src_valid;
  logic                  src_ready;
  logic                  data_out_valid;
  logic                  data_out_ready;

  modport master (
    output start,
    output output_size,
    output operation_mode,
    output src_valid,
    output data_out_ready,
    input  src_ready,
    input  data_out_valid
  );

  modport slave (
    input  start,
    input  output_size,
    input  operation_mode,
    input  src_valid,
    input  data_out_ready,
    output src_ready,
    output data_out_valid
  );
endinterface

// File: rtl/dump_control.sv
// SHAKE squeeze/output sequencer driving the dump datapath controls.
// Optional block counter output enabled by DUMP_CONTROL_BLOCK_COUNT_EN.
module dump_control #(
  parameter int         SIZE_WIDTH        = 32,
  parameter logic [1:0] SHAKE256_MODE_VEC = 2'b01
) (
  input  logic                  clk,
  input  logic                  rst,
  dump_control_if.slave         bus,
  input  logic                  output_buffer_empty,
`ifdef DUMP_CONTROL_BLOCK_COUNT_EN
  output logic [15:0]           blocks_dumped,
`endif
  output logic [SIZE_WIDTH-1:0] remaining_size,
  output logic                  output_buffer_we,
  output logic                  output_counter_load,
  output logic                  valid_bytes_enable,
  output logic                  output_buffer_shift_en,
  output logic                  last_output_block,
  output logic                  output_counter_rst,
  output logic                  valid_bytes_reset,
  output logic                  busy,
  output logic                  done
);

  typedef logic [SIZE_WIDTH-1:0] size_t;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DUMP = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam size_t RATE_128 = size_t'(1344);
  localparam size_t RATE_256 = size_t'(1088);

  logic [1:0] state_q, state_d;
  size_t      rem_q, rem_d;
  logic       mode256_q, mode256_d;
  logic       last_q, last_d;

  size_t rate;
  size_t req_size;
  logic  fits;
  logic  in_idle, in_wait, in_dump, in_done;
  logic  load;
  logic  dov;

  assign rate     = mode256_q ? RATE_256 : RATE_128;
  // Requests are byte granular; the low three bits carry no data.
  assign req_size = bus.output_size & ~size_t'(7);
  assign fits     = rem_q <= rate;

  assign in_idle = state_q == S_IDLE;
  assign in_wait = state_q == S_WAIT;
  assign in_dump = state_q == S_DUMP;
  assign in_done = state_q == S_DONE;

  assign load = in_wait & bus.src_valid;
  assign dov  = in_dump & ~output_buffer_empty;

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    mode256_d = mode256_q;
    last_d    = last_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          mode256_d = bus.operation_mode == SHAKE256_MODE_VEC;
          rem_d     = req_size;
          state_d   = (req_size == '0) ? S_DONE : S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.src_valid) begin
          last_d  = fits;
          state_d = S_DUMP;
        end
      end
      S_DUMP: begin
        if (output_buffer_empty) begin
          if (last_q) begin
            state_d = S_DONE;
          end else begin
            // last_q clear implies rem_q > rate, so no underflow.
            rem_d   = rem_q - rate;
            state_d = S_WAIT;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      rem_q     <= '0;
      mode256_q <= 1'b0;
      last_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      mode256_q <= mode256_d;
      last_q    <= last_d;
    end
  end

`ifdef DUMP_CONTROL_BLOCK_COUNT_EN
  logic [15:0] blk_cnt_q, blk_cnt_d;

  always_comb begin
    blk_cnt_d = blk_cnt_q;
    if (in_idle && bus.start) begin
      blk_cnt_d = '0;
    end else if (load && blk_cnt_q != 16'hFFFF) begin
      blk_cnt_d = blk_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blk_cnt_q <= '0;
    end else begin
      blk_cnt_q <= blk_cnt_d;
    end
  end

  assign blocks_dumped = blk_cnt_q;
`endif

  assign bus.src_ready      = in_wait;
  assign bus.data_out_valid = dov;

  assign remaining_size         = rem_q;
  assign output_buffer_we       = load;
  assign output_counter_load    = load;
  assign valid_bytes_enable     = load;
  assign output_buffer_shift_en = dov & bus.data_out_ready;
  assign last_output_block      = (in_wait & fits) | (in_dump & last_q);
  assign output_counter_rst     = in_idle;
  assign valid_bytes_reset      = in_idle | in_done;
  assign busy                   = ~in_idle;
  assign done                   = in_done;

endmodule

// File: tb/tb_dump_control.sv
// Bench for dump_control: datapath stand-in, reference model
// and per-cycle compare plus literal scenario checks.
module tb_dump_control;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dump_control_if #(.SIZE_WIDTH(32)) bus ();

  logic        obe;
  logic [31:0] rem;
  logic        we, cl, vbe, sh, lst, crst, vbr, busy, done;
`ifdef DUMP_CONTROL_BLOCK_COUNT_EN
  logic [15:0] bd;
`endif

  dump_control #(.SIZE_WIDTH(32)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .bus                    (bus),
    .output_buffer_empty    (obe),
`ifdef DUMP_CONTROL_BLOCK_COUNT_EN
    .blocks_dumped          (bd),
`endif
    .remaining_size         (rem),
    .output_buffer_we       (we),
    .output_counter_load    (cl),
    .valid_bytes_enable     (vbe),
    .output_buffer_shift_en (sh),
    .last_output_block      (lst),
    .output_counter_rst     (crst),
    .valid_bytes_reset      (vbr),
    .busy                   (busy),
    .done                   (done)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int cur_rate = 1344;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, longint act, longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d",
               name, cyc, act, exp);
    end
  endtask

  // Datapath stand-in: 64-bit words per block, empty when count is 0.
  int dp_cnt;
  assign obe = (dp_cnt == 0);
  always @(posedge clk or posedge rst) begin
    if (rst) dp_cnt <= 0;
    else if (crst) dp_cnt <= 0;
    else if (cl)
      dp_cnt <= ((int'(rem) < cur_rate ? int'(rem) : cur_rate) + 63) / 64;
    else if (sh) dp_cnt <= dp_cnt - 1;
  end

  // Reference model: words left in the current block, bits left overall.
  typedef enum {P_IDLE, P_WAIT, P_DUMP, P_FIN} ph_t;
  ph_t ph;
  int  m_rem, m_left, m_rate;
  bit  m_last;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ph <= P_IDLE; m_rem <= 0; m_left <= 0; m_last <= 0; m_rate <= 1344;
    end else begin
      case (ph)
        P_IDLE: if (bus.start) begin
          m_rate <= (bus.operation_mode == 2'b01) ? 1088 : 1344;
          m_rem  <= (int'(bus.output_size) / 8) * 8;
          ph     <= (int'(bus.output_size) / 8 == 0) ? P_FIN : P_WAIT;
        end
        P_WAIT: if (bus.src_valid) begin
          m_left <= ((m_rem < m_rate ? m_rem : m_rate) + 63) / 64;
          m_last <= m_rem <= m_rate;
          ph     <= P_DUMP;
        end
        P_DUMP: begin
          if (m_left == 0) begin
            if (m_last) ph <= P_FIN;
            else begin
              m_rem <= m_rem - m_rate;
              ph    <= P_WAIT;
            end
          end else if (bus.data_out_ready) m_left <= m_left - 1;
        end
        P_FIN: ph <= P_IDLE;
      endcase
    end
  end

  int n_loads, n_words, n_done, n_busy, n_sr, done_cyc;
  bit load_last[$];
  int load_rem[$];

  always @(negedge clk) begin
    bit e_dov;
    e_dov = (ph == P_DUMP) && (m_left > 0);
    chk("busy", busy, ph != P_IDLE);
    chk("src_ready", bus.src_ready, ph == P_WAIT);
    chk("buffer_we", we, ph == P_WAIT && bus.src_valid);
    chk("counter_load", cl, ph == P_WAIT && bus.src_valid);
    chk("vb_enable", vbe, ph == P_WAIT && bus.src_valid);
    chk("last_block", lst, (ph == P_WAIT && m_rem <= m_rate) ||
                           (ph == P_DUMP && m_last));
    chk("data_out_valid", bus.data_out_valid, e_dov);
    chk("shift_en", sh, e_dov && bus.data_out_ready);
    chk("counter_rst", crst, ph == P_IDLE);
    chk("vb_reset", vbr, ph == P_IDLE || ph == P_FIN);
    chk("done", done, ph == P_FIN);
    chk("remaining", rem, m_rem);
    if (we) begin
      n_loads++;
      load_last.push_back(lst);
      load_rem.push_back(int'(rem));
    end
    if (sh) n_words++;
    if (done) begin n_done++; done_cyc = cyc; end
    if (busy) n_busy++;
    if (bus.src_ready) n_sr++;
  end

  int t0;

  task automatic clr();
    n_loads = 0; n_words = 0; n_done = 0; n_busy = 0; n_sr = 0;
    done_cyc = -1;
    load_last.delete();
    load_rem.delete();
  endtask

  task automatic go(input logic [1:0] mode, input int size);
    clr();
    @(posedge clk); #1;
    cur_rate = (mode == 2'b01) ? 1088 : 1344;
    bus.operation_mode = mode;
    bus.output_size = size;
    bus.start = 1'b1;
    t0 = cyc;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit tog);
    int k = 0;
    while (n_done == 0 && k < budget) begin
      @(posedge clk); #1;
      if (tog) bus.data_out_ready = ~bus.data_out_ready;
      k++;
    end
    chk("done_seen", n_done, 1);
    bus.data_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.output_size = '0;
    bus.operation_mode = 2'b00;
    bus.src_valid = 1'b1;
    bus.data_out_ready = 1'b1;
    #2;
    chk("rst_remaining", rem, 0);
    chk("rst_src_ready", bus.src_ready, 0);
    chk("rst_dov", bus.data_out_valid, 0);
    chk("rst_we", we, 0);
    chk("rst_shift", sh, 0);
    chk("rst_crst", crst, 1);
    chk("rst_vbr", vbr, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // SHAKE128, 256 bits: one final block of 4 words.
    go(2'b00, 256);
    wait_done(100, 0);
    chk("t1_loads", n_loads, 1);
    chk("t1_last", load_last[0], 1);
    chk("t1_words", n_words, 4);
    chk("t1_done_lat", done_cyc - t0, 7);
    chk("t1_done_cnt", n_done, 1);

    // SHAKE256, exactly one rate block.
    go(2'b01, 1088);
    wait_done(100, 0);
    chk("t2_loads", n_loads, 1);
    chk("t2_last", load_last[0], 1);
    chk("t2_words", n_words, 17);
    chk("t2_src_ready", n_sr, 1);
    chk("t2_done_lat", done_cyc - t0, 20);

    // SHAKE128, 1400 bits: full block then 56-bit tail.
    go(2'b00, 1400);
    wait_done(200, 0);
    chk("t3_loads", n_loads, 2);
    chk("t3_last0", load_last[0], 0);
    chk("t3_last1", load_last[1], 1);
    chk("t3_rem0", load_rem[0], 1400);
    chk("t3_rem1", load_rem[1], 56);
    chk("t3_words", n_words, 22);
    chk("t3_done_lat", done_cyc - t0, 27);
`ifdef DUMP_CONTROL_BLOCK_COUNT_EN
    chk("t3_blocks", bd, 2);
`endif

    // Zero-length request.
    go(2'b00, 0);
    wait_done(20, 0);
    chk("t4_src_ready", n_sr, 0);
    chk("t4_busy", n_busy, 1);
    chk("t4_done_lat", done_cyc - t0, 1);

    // SHAKE128, 512 bits with ready toggling.
    go(2'b00, 512);
    wait_done(200, 1);
    chk("t5_loads", n_loads, 1);
    chk("t5_words", n_words, 8);

    // Low size bits ignored: 263 -> 256.
    go(2'b00, 263);
    wait_done(100, 0);
    chk("t6_rem", load_rem[0], 256);
    chk("t6_words", n_words, 4);

    // 1352 bits: one rate block plus an 8-bit tail.
    go(2'b00, 1352);
    wait_done(200, 0);
    chk("t7_loads", n_loads, 2);
    chk("t7_rem1", load_rem[1], 8);
    chk("t7_words", n_words, 22);

    // Reset after the third word of a 21-word block.
    go(2'b00, 1344);
    begin
      int k = 0;
      while (n_words < 3 && k < 100) begin
        @(posedge clk);
        k++;
      end
    end
    chk("t8_words_before", n_words, 3);
    #1 rst = 1'b1;
    #1;
    chk("t8_busy", busy, 0);
    chk("t8_src_ready", bus.src_ready, 0);
    chk("t8_dov", bus.data_out_valid, 0);
    chk("t8_shift", sh, 0);
    chk("t8_crst", crst, 1);
    chk("t8_vbr", vbr, 1);
    chk("t8_done", done, 0);
    chk("t8_rem", rem, 0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    chk("t8_no_done", n_done, 0);

    go(2'b00, 256);
    wait_done(100, 0);
    chk("t9_loads", n_loads, 1);
    chk("t9_words", n_words, 4);
    chk("t9_done_lat", done_cyc - t0, 7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
